cnt_dwn: RTL and testbench

- Loadable down-counter with a terminal-count flag.
- A value on `in` is loaded under `latch` and decremented once per clock under `dec`, saturating at zero.
- `zero` is a registered done flag. It asserts when the count reaches zero through a decrement or a load of zero, and stays clear after reset until that happens.
- Used as a small timer/event counter in control paths.

---
 rtl/cnt_dwn_pkg.sv | 7 +
 rtl/cnt_dwn.sv | 50 +++++
 tb/tb_cnt_dwn.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cnt_dwn_pkg.sv
// Shared constants for the loadable down-counter.
// Keeps the default counter width in one place for the counter and its users.
package cnt_dwn_pkg;

    localparam int CNT_DWN_WIDTH = 4;

endpackage : cnt_dwn_pkg

// File: rtl/cnt_dwn.sv
// Loadable down-counter with a registered terminal-count flag.
// Decrement has priority over load and saturates at zero; zero asserts only via decrement-to-zero or load-of-zero.
module cnt_dwn
    import cnt_dwn_pkg::*;
#(
    parameter int WIDTH = CNT_DWN_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             latch,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_d;
    logic             zero_q;
    logic             zero_d;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        count_d = count;
        zero_d  = zero_q;
        if (dec) begin
            // A decrement on an empty counter is a no-op and also swallows a concurrent load.
            if (count != '0) begin
                count_d = count - WIDTH'(1);
                zero_d  = (count == WIDTH'(1));
            end
        end else if (latch) begin
            count_d = in;
            zero_d  = (in == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            zero_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
            count  <= count_d;
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;

endmodule : cnt_dwn

// File: tb/tb_cnt_dwn.sv
// Scoreboard bench for cnt_dwn: a stimulus process pushes model predictions, a monitor pops and compares after each edge.
// Directed test-plan steps are followed by randomized traffic with occasional asynchronous resets.
module tb_cnt_dwn;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    typedef struct {
        int cnt;
        bit zr;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_s;
    logic             latch_s;
    logic             dec_s;
    logic             zero_s;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Behavioural reference state.
    int m_cnt  = 0;
    bit m_zero = 0;

    cnt_dwn #(.WIDTH(WIDTH)) cnt_dwn (
        .clk  (clk),
        .rst  (rst),
        .in   (in_s),
        .latch(latch_s),
        .dec  (dec_s),
        .zero (zero_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_zero = 0;
    endtask

    // Apply one cycle of stimulus and predict the state after the next rising edge.
    task automatic drive(input int v, input bit l, input bit d);
        int val;
        val = v % (MAXV + 1);
        @(negedge clk);
        in_s    = WIDTH'(val);
        latch_s = l;
        dec_s   = d;
        if (d) begin
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_zero = 1;
            end
        end else if (l) begin
            m_cnt  = val;
            m_zero = (val == 0);
        end
        sb.push_back('{cnt: m_cnt, zr: m_zero});
    endtask

    task automatic async_reset_check(input string tag);
        rst     = 1'b1;
        latch_s = 1'b0;
        dec_s   = 1'b0;
        #1;
        model_reset();
        check({tag, "_count"}, int'(cnt_dwn.count), m_cnt);
        check({tag, "_zero"}, int'(zero_s), int'(m_zero));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares the DUT against the oldest prediction shortly after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("count", int'(cnt_dwn.count), e.cnt);
                check("zero", int'(zero_s), int'(e.zr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b0;
        in_s    = '0;
        latch_s = 1'b0;
        dec_s   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("reset_count", int'(cnt_dwn.count), 0);
        check("reset_zero", int'(zero_s), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Test-plan directed steps.
        drive(1, 0, 1);           // dec on empty after reset: stays 0, flag not armed
        drive(1, 1, 0);           // load 1
        drive(1, 1, 1);           // dec beats latch -> 0, zero=1
        drive(0, 1, 1);           // saturated: load suppressed, zero held
        drive(MAXV, 1, 0);        // load all-ones
        for (int i = 0; i < MAXV + 1; i++) drive(0, 0, 1);  // 15 steps to zero plus one saturated
        drive(0, 1, 0);           // load zero arms the flag
        drive(7, 1, 0);           // load nonzero clears it
        drive(3, 0, 0);           // hold

        // Asynchronous reset mid-count, between edges.
        drive(5, 1, 0);
        @(posedge clk);
        #3;
        async_reset_check("async_mid");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                @(negedge clk);
                #2;
                async_reset_check("async_rand");
            end else begin
                drive($urandom_range(0, MAXV), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
            end
        end

        @(posedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_cnt_dwn
